gpp_boot_loader: RTL and testbench

Synthesisable successor to the bench-driven SRAM preload sequence. It streams a program image from a valid/ready source into the GPP instruction SRAM through that SRAM's backdoor write port. It then releases the GPP reset, counts run cycles until Done, and reports pass/timeout. It sits between an external image source (ROM, UART or bench) and GPP_TOP, and replaces hand-sequenced memory reset, load and core reset.

---
 rtl/gpp_boot_loader_pkg.sv | 23 ++
 rtl/gpp_boot_loader_timer.sv | 37 +++
 rtl/gpp_boot_loader.sv | 191 +++++++++++++++++++
 tb/tb_gpp_boot_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpp_boot_loader_pkg.sv
// Shared definitions for the GPP boot loader: default widths, state encoding
// and the load-length clamp.
package gpp_boot_loader_pkg;

  localparam int unsigned D_WIDTH_DEF  = 32;
  localparam int unsigned SA_WIDTH_DEF = 5;
  localparam int unsigned SL_WIDTH_DEF = SA_WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MRST    = 3'd1,
    S_LOAD    = 3'd2,
    S_GRST    = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5,
    S_TIMEOUT = 3'd6
  } boot_state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len < depth) ? len : depth;
  endfunction

endpackage

// File: rtl/gpp_boot_loader_timer.sv
// Saturating up-counter with synchronous clear/enable and a terminal-count
// flag against a programmable terminal value.
module boot_run_timer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] term,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == term);

endmodule

// File: rtl/gpp_boot_loader.sv
// Boot sequencer: streams an image into the GPP instruction SRAM backdoor,
// releases the core reset and watches for Done or a run timeout.
module gpp_boot_loader
  import gpp_boot_loader_pkg::*;
#(
  parameter int unsigned D_WIDTH    = D_WIDTH_DEF,
  parameter int unsigned SA_WIDTH   = SA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [SA_WIDTH:0]    Load_Len,
  input  logic                 In_Valid,
  input  logic [D_WIDTH-1:0]   In_Data,
  output logic                 In_Ready,
  output logic                 Mem_Rst,
  output logic [SA_WIDTH-1:0]  Mem_Addr,
  output logic [D_WIDTH-1:0]   Mem_Data,
  output logic                 Mem_En,
  output logic                 Mem_RW,
  output logic                 Gpp_Rst,
  input  logic                 Gpp_Done,
  output logic                 Busy,
  output logic                 Pass,
  output logic                 Timeout,
  output logic [CNT_WIDTH-1:0] Run_Cycles
);

  localparam int unsigned SL_WIDTH = SA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] RST_TERM = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_TERM = CNT_WIDTH'(MAX_CYCLES - 1);

  boot_state_e         state_q, state_d;
  logic [SL_WIDTH-1:0] len_q, len_d;
  logic [SL_WIDTH-1:0] cnt_q, cnt_d;
  logic [SL_WIDTH-1:0] cnt_inc;
  logic                in_ready_q, in_ready_d;
  logic                mem_rst_q, mem_rst_d;
  logic [SA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_rw_q, mem_rw_d;
  logic                gpp_rst_q, gpp_rst_d;
  logic                busy_q, busy_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic                hs;
  logic                run_clr, run_en, run_tc;
  logic                grst_clr, grst_tc;
  logic [CNT_WIDTH-1:0] run_cnt;
  logic [CNT_WIDTH-1:0] grst_cnt_unused;

  boot_run_timer #(.CNT_WIDTH(CNT_WIDTH)) u_run_timer (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (run_clr),
    .en    (run_en),
    .term  (RUN_TERM),
    .count (run_cnt),
    .tc    (run_tc)
  );

  // Held clear outside S_GRST so every entry starts counting from zero.
  boot_run_timer #(.CNT_WIDTH(CNT_WIDTH)) u_grst_timer (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (grst_clr),
    .en    (1'b1),
    .term  (RST_TERM),
    .count (grst_cnt_unused),
    .tc    (grst_tc)
  );

  assign grst_clr = (state_q != S_GRST);
  assign hs       = (state_q == S_LOAD) && in_ready_q && In_Valid;
  assign cnt_inc  = cnt_q + SL_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_en_d   = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    run_clr    = 1'b0;
    run_en     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (Start) begin
          len_d     = SL_WIDTH'(clamp_len(int'(Load_Len), DEPTH));
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          run_clr   = 1'b1;
          state_d   = S_MRST;
        end
      end
      S_MRST: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? S_GRST : S_LOAD;
      end
      S_LOAD: begin
        if (hs) begin
          mem_en_d   = 1'b1;
          mem_addr_d = cnt_q[SA_WIDTH-1:0];
          mem_data_d = In_Data;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_GRST;
          end
        end
      end
      S_GRST: begin
        if (grst_tc) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Done takes priority over a coincident timeout; the counter only
        // advances on cycles that stay in S_RUN.
        if (Gpp_Done) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else if (run_tc) begin
          timeout_d = 1'b1;
          state_d   = S_TIMEOUT;
        end else begin
          run_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_rw_d   = mem_en_d;
    in_ready_d = (state_d == S_LOAD);
    mem_rst_d  = (state_d == S_MRST);
    gpp_rst_d  = (state_d != S_RUN);
    busy_d     = (state_d inside {S_MRST, S_LOAD, S_GRST, S_RUN});
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      mem_rst_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_en_q   <= 1'b0;
      mem_rw_q   <= 1'b0;
      gpp_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      mem_rst_q  <= mem_rst_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_en_q   <= mem_en_d;
      mem_rw_q   <= mem_rw_d;
      gpp_rst_q  <= gpp_rst_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  assign In_Ready   = in_ready_q;
  assign Mem_Rst    = mem_rst_q;
  assign Mem_Addr   = mem_addr_q;
  assign Mem_Data   = mem_data_q;
  assign Mem_En     = mem_en_q;
  assign Mem_RW     = mem_rw_q;
  assign Gpp_Rst    = gpp_rst_q;
  assign Busy       = busy_q;
  assign Pass       = pass_q;
  assign Timeout    = timeout_q;
  assign Run_Cycles = run_cnt;

endmodule

// File: tb/tb_gpp_boot_loader.sv
// Scoreboard bench for gpp_boot_loader: the stimulus side queues expected
// SRAM writes and boot results, a monitor pops and compares them.
module tb_gpp_boot_loader;

  localparam int D_W   = 32;
  localparam int SA_W  = 5;
  localparam int DEPTH = 32;
  localparam int RSTC  = 3;
  localparam int CNT_W = 16;
  localparam int MAXC  = 24;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Start;
  logic [SA_W:0]     Load_Len;
  logic              In_Valid;
  logic [D_W-1:0]    In_Data;
  logic              In_Ready;
  logic              Mem_Rst;
  logic [SA_W-1:0]   Mem_Addr;
  logic [D_W-1:0]    Mem_Data;
  logic              Mem_En;
  logic              Mem_RW;
  logic              Gpp_Rst;
  logic              Gpp_Done;
  logic              Busy;
  logic              Pass;
  logic              Timeout;
  logic [CNT_W-1:0]  Run_Cycles;

  always #5 Clk = ~Clk;

  gpp_boot_loader #(
    .D_WIDTH(D_W), .SA_WIDTH(SA_W), .DEPTH(DEPTH), .RST_CYCLES(RSTC),
    .CNT_WIDTH(CNT_W), .MAX_CYCLES(MAXC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Load_Len(Load_Len),
    .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
    .Mem_Rst(Mem_Rst), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .Mem_En(Mem_En), .Mem_RW(Mem_RW), .Gpp_Rst(Gpp_Rst), .Gpp_Done(Gpp_Done),
    .Busy(Busy), .Pass(Pass), .Timeout(Timeout), .Run_Cycles(Run_Cycles)
  );

  typedef struct {
    logic [SA_W-1:0] addr;
    logic [D_W-1:0]  data;
  } wr_t;

  typedef struct {
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   aborting = 1'b0;

  // Monitor state
  int   cyc = 0;
  int   last_we = -100;
  int   last_mrst = -100;
  int   mrst_cnt = 0;
  bit   hs_prev = 1'b0;
  bit   wrote = 1'b0;
  bit   busy_prev = 1'b0;
  bit   grst_prev = 1'b1;

  task automatic fail(input string name, input longint got, input longint want);
    n_err++;
    $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  initial begin : monitor
    wr_t  w;
    res_t r;
    int   want_fall;
    forever begin
      @(negedge Clk);
      cyc++;
      n_vec++;
      if (Mem_En !== hs_prev || Mem_RW !== hs_prev)
        fail("mem_en_rw", {Mem_En, Mem_RW}, {hs_prev, hs_prev});
      if (Mem_En === 1'b1) begin
        last_we = cyc;
        wrote   = 1'b1;
        n_vec++;
        if (exp_wr.size() == 0) begin
          fail("unexpected_write", Mem_Addr, 0);
        end else begin
          w = exp_wr.pop_front();
          if (Mem_Addr !== w.addr || Mem_Data !== w.data)
            fail("write_addr_data", {Mem_Addr, Mem_Data}, {w.addr, w.data});
        end
      end
      if (Mem_Rst === 1'b1) begin
        mrst_cnt++;
        last_mrst = cyc;
      end
      if (grst_prev && Gpp_Rst === 1'b0) begin
        want_fall = wrote ? last_we + RSTC : last_mrst + RSTC + 1;
        n_vec++;
        if (cyc != want_fall) fail("gpp_rst_release_cycle", cyc, want_fall);
      end
      if (busy_prev && Busy === 1'b0) begin
        if (!aborting) begin
          n_vec++;
          if (exp_res.size() == 0) begin
            fail("unexpected_boot_end", 0, 1);
          end else begin
            r = exp_res.pop_front();
            if (Pass !== r.pass || Timeout !== r.timeout || Run_Cycles !== r.cycles)
              fail("boot_result_pass_to_cycles", {Pass, Timeout, Run_Cycles},
                   {r.pass, r.timeout, r.cycles});
          end
          n_vec++;
          if (Gpp_Rst !== 1'b1 || In_Ready !== 1'b0 || mrst_cnt != 1)
            fail("parked_gpprst_ready_mrstcnt", {Gpp_Rst, In_Ready, 8'(mrst_cnt)},
                 {1'b1, 1'b0, 8'd1});
        end
        mrst_cnt = 0;
        wrote    = 1'b0;
      end
      hs_prev   = (In_Valid === 1'b1) && (In_Ready === 1'b1) && (Rst === 1'b0);
      busy_prev = (Busy === 1'b1);
      grst_prev = (Gpp_Rst !== 1'b0);
    end
  end

  task automatic check_reset(input string name);
    logic [60:0] got, want;
    got  = {In_Ready, Mem_Rst, Mem_Addr, Mem_Data, Mem_En, Mem_RW, Gpp_Rst,
            Busy, Pass, Timeout, Run_Cycles};
    want = {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    n_vec++;
    if (got !== want) fail(name, got, want);
  endtask

  // vmode: 0 = valid held, 1 = toggling, 2 = random. done_at < 0 = never.
  // abort_after > 0 resets the loader right after that many accepts.
  task automatic run_boot(input int len, input int vmode, input int done_at,
                          input int abort_after, input bit fixed_data);
    int           eff;
    int           fed;
    int           budget;
    bit           tog;
    bit           hs;
    logic [D_W-1:0] data[$];
    logic [D_W-1:0] d;
    res_t         r;
    wr_t          w;

    eff = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < eff; i++) begin
      d = fixed_data ? D_W'(32'h11 * (i + 1)) : D_W'($urandom);
      data.push_back(d);
      w.addr = SA_W'(i);
      w.data = d;
      exp_wr.push_back(w);
    end
    if (abort_after <= 0) begin
      if (done_at >= 0 && done_at < MAXC) begin
        r.pass = 1'b1; r.timeout = 1'b0; r.cycles = CNT_W'(done_at);
      end else begin
        r.pass = 1'b0; r.timeout = 1'b1; r.cycles = CNT_W'(MAXC - 1);
      end
      exp_res.push_back(r);
    end

    Start    = 1'b1;
    Load_Len = (SA_W + 1)'(len);
    @(posedge Clk); #1;
    Start    = 1'b0;
    Load_Len = (SA_W + 1)'($urandom);

    fed    = 0;
    budget = 0;
    tog    = 1'b1;
    while (fed < eff) begin
      case (vmode)
        0:       In_Valid = 1'b1;
        1:       begin In_Valid = tog; tog = ~tog; end
        default: In_Valid = 1'($urandom);
      endcase
      In_Data  = data[fed];
      Gpp_Done = ($urandom_range(0, 3) == 0);
      Start    = (vmode == 2) && ($urandom_range(0, 7) == 0);
      hs       = In_Valid && (In_Ready === 1'b1);
      @(posedge Clk); #1;
      if (hs) begin
        fed++;
        if (fed == abort_after) begin
          In_Valid = 1'b0;
          Gpp_Done = 1'b0;
          Start    = 1'b0;
          aborting = 1'b1;
          Rst      = 1'b1;
          @(posedge Clk); #1;
          Rst = 1'b0;
          check_reset("reset_after_abort");
          exp_wr.delete();
          @(negedge Clk); #1;
          aborting = 1'b0;
          return;
        end
        if (fed == eff) begin
          n_vec++;
          if (In_Ready !== 1'b0) fail("in_ready_after_last_accept", In_Ready, 0);
        end
      end
      budget++;
      if (budget > 400) begin
        n_vec++;
        fail("load_budget_expired", fed, eff);
        return;
      end
    end
    Start    = 1'b0;
    Gpp_Done = 1'b0;

    budget = 0;
    while (Gpp_Rst !== 1'b0 && budget < 50) begin
      In_Valid = 1'($urandom);
      @(posedge Clk); #1;
      budget++;
    end
    if (budget >= 50) begin
      n_vec++;
      fail("gpp_rst_release_timeout", Gpp_Rst, 0);
      return;
    end

    if (done_at >= 0) begin
      repeat (done_at) begin
        In_Valid = 1'($urandom);
        @(posedge Clk); #1;
      end
      Gpp_Done = 1'b1;
      @(posedge Clk); #1;
      Gpp_Done = 1'b0;
    end

    budget = 0;
    while (Busy !== 1'b0 && budget < MAXC + 20) begin
      @(posedge Clk); #1;
      budget++;
    end
    if (budget >= MAXC + 20) begin
      n_vec++;
      fail("busy_drop_timeout", Busy, 0);
    end
    In_Valid = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin : stimulus
    Rst      = 1'b1;
    Start    = 1'b0;
    Load_Len = '0;
    In_Valid = 1'b0;
    In_Data  = '0;
    Gpp_Done = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_reset("reset_values");

    run_boot(4,  0, 10,       -1, 1'b1);
    run_boot(3,  1, 5,        -1, 1'b0);
    run_boot(40, 0, -1,       -1, 1'b0);
    run_boot(2,  0, MAXC - 1, -1, 1'b0);
    run_boot(0,  0, 0,        -1, 1'b0);
    run_boot(6,  0, -1,        2, 1'b0);
    run_boot(5,  2, 7,        -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_boot(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 31)) - 1, -1, 1'b0);
    end

    repeat (4) @(posedge Clk);
    #1;
    n_vec++;
    if (exp_wr.size() != 0 || exp_res.size() != 0)
      fail("scoreboard_leftover", exp_wr.size() + exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
